w_slave_ssp: RTL and testbench

// Wishbone slave downstream of w_master; bridges ARM bus accesses to the SSP serial core.

---
 rtl/w_slave_ssp_pkg.sv | 69 ++++++
 rtl/w_slave_ssp_if.sv | 29 ++
 rtl/w_slave_ssp_fifo.sv | 72 +++++++
 rtl/w_slave_ssp.sv | 159 +++++++++++++++
 tb/tb_w_slave_ssp.sv | 291 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/w_slave_ssp_pkg.sv
// ---------------------------------------------------------------------------
// w_slave_ssp_pkg
// Shared definitions for the SSP Wishbone slave: register offsets, STATUS and
// CTRL bit positions, parameter defaults, and a STATUS word packing helper.
// ---------------------------------------------------------------------------
package w_slave_ssp_pkg;

  localparam logic [25:0] BASE_ADDR_DEF  = 26'h0000100;
  localparam int          FIFO_DEPTH_DEF = 4;

  // Word offset inside the 16-byte register window (adr_i[3:2]).
  typedef enum logic [1:0] {
    REG_TXDATA = 2'd0,
    REG_RXDATA = 2'd1,
    REG_STATUS = 2'd2,
    REG_CTRL   = 2'd3
  } reg_sel_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ACK  = 2'd1,
    ST_WAIT = 2'd2
  } bus_state_e;

  // STATUS bit positions.
  localparam int ST_TX_FULL    = 0;
  localparam int ST_TX_EMPTY   = 1;
  localparam int ST_RX_FULL    = 2;
  localparam int ST_RX_EMPTY   = 3;
  localparam int ST_RX_OVF     = 4;
  localparam int ST_TX_OVF     = 5;
  localparam int ST_TX_CNT_LSB = 8;
  localparam int ST_RX_CNT_LSB = 12;

  // CTRL write-one-to-clear bit positions (never stored, read back as 0).
  localparam int CTRL_CLR_RXOVF = 4;
  localparam int CTRL_CLR_TXOVF = 5;

  // Stored CTRL bits; field order matches CTRL[2:0] = {RXIE, TXIE, EN}.
  typedef struct packed {
    logic rxie;
    logic txie;
    logic en;
  } ctrl_t;

  function automatic logic [31:0] pack_status(
    input logic       tx_full,
    input logic       tx_empty,
    input logic       rx_full,
    input logic       rx_empty,
    input logic       rx_ovf,
    input logic       tx_ovf,
    input logic [2:0] tx_cnt,
    input logic [2:0] rx_cnt
  );
    logic [31:0] s;
    s                        = '0;
    s[ST_TX_FULL]            = tx_full;
    s[ST_TX_EMPTY]           = tx_empty;
    s[ST_RX_FULL]            = rx_full;
    s[ST_RX_EMPTY]           = rx_empty;
    s[ST_RX_OVF]             = rx_ovf;
    s[ST_TX_OVF]             = tx_ovf;
    s[ST_TX_CNT_LSB +: 3]    = tx_cnt;
    s[ST_RX_CNT_LSB +: 3]    = rx_cnt;
    return s;
  endfunction

endpackage

// File: rtl/w_slave_ssp_if.sv
// ---------------------------------------------------------------------------
// w_slave_ssp_if
// Wishbone-style bus between w_master and the SSP slave.
//   adr_i[25:0]  byte address      dat_i[31:0] write data   we_i  1=write
//   stb_i        strobe            cyc_i       cycle valid  tagn_i transfer tag
//   dat_o[31:0]  read data         ack_o       acknowledge  tagn_o tag echo
// Signal names keep the slave-side view (_i into slave, _o out of slave).
// ---------------------------------------------------------------------------
interface w_slave_ssp_if;
  logic [25:0] adr_i;
  logic [31:0] dat_i;
  logic        we_i;
  logic        stb_i;
  logic        cyc_i;
  logic        tagn_i;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        tagn_o;

  modport master (
    output adr_i, dat_i, we_i, stb_i, cyc_i, tagn_i,
    input  dat_o, ack_o, tagn_o
  );

  modport slave (
    input  adr_i, dat_i, we_i, stb_i, cyc_i, tagn_i,
    output dat_o, ack_o, tagn_o
  );
endinterface

// File: rtl/w_slave_ssp_fifo.sv
// ---------------------------------------------------------------------------
// w_slave_ssp_fifo
// Synchronous FIFO with show-ahead output.
//   clk_i, rst_i  clock, asynchronous active-high reset (empties the FIFO)
//   push, din     write request and data; dropped when full unless a pop
//                 happens in the same cycle
//   pop           read request; ignored when empty
//   dout          current head (undefined content when empty)
//   full, empty   status
//   count         number of stored entries, 0..DEPTH
// ---------------------------------------------------------------------------
module w_slave_ssp_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH),
  localparam int CW    = AW + 1
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty,
  output logic [CW-1:0]    count
);

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0]    wr_ptr;
  logic [AW-1:0]    rd_ptr;
  logic [CW-1:0]    cnt;
  logic             do_push;
  logic             do_pop;

  assign empty = (cnt == '0);
  assign full  = (cnt == CW'(DEPTH));
  assign count = cnt;

  // A pop frees a slot in the same cycle, so a push onto a full FIFO is
  // accepted when paired with a pop; a pop on an empty FIFO never happens.
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values regardless of statement order.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      cnt    <= '0;
    end else begin
      // Power-of-two depth: pointers wrap by natural overflow.
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
      case ({do_push, do_pop})
        2'b10:   cnt <= cnt + 1'b1;
        2'b01:   cnt <= cnt - 1'b1;
        default: cnt <= cnt;
      endcase
    end
  end

  // NOTE: the storage array has no reset; emptiness is tracked by the
  // pointers and count, so resetting it would only cost flops.
  always_ff @(posedge clk_i) begin
    if (do_push) mem[wr_ptr] <= din;
  end

  assign dout = mem[rd_ptr];

endmodule

// File: rtl/w_slave_ssp.sv
// ---------------------------------------------------------------------------
// w_slave_ssp
// Wishbone slave bridging ARM bus accesses to the SSP serial core. Decodes a
// 4-register window (TXDATA, RXDATA, STATUS, CTRL), buffers bytes in TX/RX
// FIFOs and raises a level interrupt.
//   clk_i, rst_i   clock, asynchronous active-high reset
//   bus            w_slave_ssp_if.slave (adr/dat/we/stb/cyc/tagn, dat_o/ack_o/tagn_o)
//   tx_data/valid  byte stream to SSP transmitter, taken on tx_valid & tx_ready
//   tx_ready       transmitter accepts tx_data
//   rx_data/valid  one-cycle push of a received byte
//   irq            level interrupt
// ---------------------------------------------------------------------------
module w_slave_ssp
  import w_slave_ssp_pkg::*;
#(
  parameter logic [25:0] BASE_ADDR  = BASE_ADDR_DEF,
  parameter int          FIFO_DEPTH = FIFO_DEPTH_DEF
) (
  input  logic                clk_i,
  input  logic                rst_i,
  w_slave_ssp_if.slave        bus,
  output logic [7:0]          tx_data,
  output logic                tx_valid,
  input  logic                tx_ready,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                irq
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  bus_state_e    state;
  ctrl_t         ctrl;
  logic          rx_ovf;
  logic          tx_ovf;

  reg_sel_e      sel;
  logic          addr_hit;
  logic          start;
  logic          wr_tx;
  logic          rd_rx;
  logic          wr_ctrl;
  logic          tx_pop;
  logic          tx_drop;
  logic          rx_drop;
  logic [31:0]   rd_word;

  logic          tx_full, tx_empty, rx_full, rx_empty;
  logic [CW-1:0] tx_count, rx_count;
  logic [7:0]    rx_head;

  // Address bits below the word select and write-data bits above the byte
  // lane carry no meaning for this block.
  logic unused_ok;
  assign unused_ok = ^{bus.adr_i[1:0], bus.dat_i[31:8]};

  // ---------------- decode ----------------
  assign addr_hit = (bus.adr_i[25:4] == BASE_ADDR[25:4]);
  assign sel      = reg_sel_e'(bus.adr_i[3:2]);
  // Side effects fire only on the first strobe cycle seen in IDLE, so a
  // long strobe cannot cause a second push/pop.
  assign start    = (state == ST_IDLE) & bus.stb_i & bus.cyc_i & addr_hit;
  assign wr_tx    = start &  bus.we_i & (sel == REG_TXDATA);
  assign rd_rx    = start & ~bus.we_i & (sel == REG_RXDATA);
  assign wr_ctrl  = start &  bus.we_i & (sel == REG_CTRL);

  assign tx_valid = ctrl.en & ~tx_empty;
  assign tx_pop   = tx_valid & tx_ready;
  assign tx_drop  = wr_tx & tx_full & ~tx_pop;
  // A full RX FIFO being read in the same cycle still accepts the new byte.
  assign rx_drop  = rx_valid & rx_full & ~rd_rx;

  // ---------------- FIFOs ----------------
  w_slave_ssp_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_tx_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (wr_tx),
    .pop   (tx_pop),
    .din   (bus.dat_i[7:0]),
    .dout  (tx_data),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count)
  );

  w_slave_ssp_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_rx_fifo (
    .clk_i (clk_i),
    .rst_i (rst_i),
    .push  (rx_valid),
    .pop   (rd_rx),
    .din   (rx_data),
    .dout  (rx_head),
    .full  (rx_full),
    .empty (rx_empty),
    .count (rx_count)
  );

  // ---------------- read mux ----------------
  // NOTE: every always_comb output gets a default first so no path leaves it
  // unassigned, which would infer a latch.
  always_comb begin
    rd_word = '0;
    case (sel)
      REG_RXDATA: rd_word = rx_empty ? 32'h0 : {24'h0, rx_head};
      REG_STATUS: rd_word = pack_status(tx_full, tx_empty, rx_full, rx_empty,
                                        rx_ovf, tx_ovf, 3'(tx_count), 3'(rx_count));
      REG_CTRL:   rd_word = {29'h0, ctrl};
      default:    rd_word = '0;
    endcase
  end

  // ---------------- bus FSM ----------------
  // dat_o/tagn_o load only when entering ACK and are held until the next
  // access, since the master samples read data the cycle after ack.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state      <= ST_IDLE;
      bus.ack_o  <= 1'b0;
      bus.dat_o  <= '0;
      bus.tagn_o <= 1'b0;
    end else begin
      bus.ack_o <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_ACK;
            bus.ack_o  <= 1'b1;
            bus.dat_o  <= bus.we_i ? 32'h0 : rd_word;
            bus.tagn_o <= bus.tagn_i;
          end
        end
        ST_ACK:  state <= ST_WAIT;
        ST_WAIT: if (!bus.stb_i) state <= ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  // ---------------- CTRL and sticky overflow flags ----------------
  // A new overflow wins over a same-cycle clear so no event is lost.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ctrl   <= '0;
      rx_ovf <= 1'b0;
      tx_ovf <= 1'b0;
    end else begin
      if (wr_ctrl) ctrl <= ctrl_t'(bus.dat_i[2:0]);

      if (rx_drop)                                 rx_ovf <= 1'b1;
      else if (wr_ctrl && bus.dat_i[CTRL_CLR_RXOVF]) rx_ovf <= 1'b0;

      if (tx_drop)                                 tx_ovf <= 1'b1;
      else if (wr_ctrl && bus.dat_i[CTRL_CLR_TXOVF]) tx_ovf <= 1'b0;
    end
  end

  assign irq = (ctrl.txie & tx_empty) | (ctrl.rxie & ~rx_empty) | rx_ovf | tx_ovf;

endmodule

// File: tb/tb_w_slave_ssp.sv
// ---------------------------------------------------------------------------
// tb_w_slave_ssp
// Self-checking bench for w_slave_ssp: a table of register accesses with
// hand-computed results, followed by directed multi-cycle sequences.
// ---------------------------------------------------------------------------
module tb_w_slave_ssp;

  localparam logic [25:0] BASE = 26'h0000100;

  logic       clk_i = 1'b0;
  logic       rst_i = 1'b0;
  logic [7:0] tx_data;
  logic       tx_valid;
  logic       tx_ready = 1'b0;
  logic [7:0] rx_data  = 8'h00;
  logic       rx_valid = 1'b0;
  logic       irq;

  int checks = 0;
  int errors = 0;

  logic       snap_txv;
  logic [7:0] snap_txd;

  w_slave_ssp_if sif ();

  w_slave_ssp #(.BASE_ADDR(BASE), .FIFO_DEPTH(4)) dut (
    .clk_i    (clk_i),
    .rst_i    (rst_i),
    .bus      (sif),
    .tx_data  (tx_data),
    .tx_valid (tx_valid),
    .tx_ready (tx_ready),
    .rx_data  (rx_data),
    .rx_valid (rx_valid),
    .irq      (irq)
  );

  always #5 clk_i = ~clk_i;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  task automatic do_reset();
    sif.stb_i = 1'b0;
    sif.cyc_i = 1'b0;
    sif.we_i  = 1'b0;
    rx_valid  = 1'b0;
    tx_ready  = 1'b0;
    rst_i     = 1'b1;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    rst_i = 1'b0;
  endtask

  // One bus access. Optionally pushes an RX byte in the strobe cycle.
  // got=0 when no ack arrives within the cycle budget.
  task automatic bus_xfer(input logic we, input logic [25:0] adr, input logic [31:0] wd,
                          input logic tg, input logic rxp, input logic [7:0] rxb,
                          output logic [31:0] rd, output logic got);
    got = 1'b0;
    rd  = '0;
    @(negedge clk_i);
    sif.adr_i  = adr;
    sif.dat_i  = wd;
    sif.we_i   = we;
    sif.tagn_i = tg;
    sif.stb_i  = 1'b1;
    sif.cyc_i  = 1'b1;
    if (rxp) begin
      rx_data  = rxb;
      rx_valid = 1'b1;
    end
    for (int i = 0; i < 4; i++) begin
      @(posedge clk_i);
      #1;
      if (i == 0) rx_valid = 1'b0;
      if (sif.ack_o) begin
        got      = 1'b1;
        rd       = sif.dat_o;
        snap_txv = tx_valid;
        snap_txd = tx_data;
        check("ack_latency", i, 0);
        check("tagn_echo", {31'h0, sif.tagn_o}, {31'h0, tg});
        break;
      end
    end
    @(negedge clk_i);
    sif.stb_i = 1'b0;
    sif.cyc_i = 1'b0;
    @(posedge clk_i);
    #1;
    if (got) check("ack_one_cycle", {31'h0, sif.ack_o}, 32'h0);
    @(posedge clk_i);
  endtask

  task automatic reg_rd(input string name, input logic [1:0] off, input logic [31:0] exp);
    logic [31:0] rd;
    logic        got;
    bus_xfer(1'b0, BASE + {22'h0, off, 2'b00}, 32'h0, 1'b1, 1'b0, 8'h00, rd, got);
    check({name, "_ack"}, {31'h0, got}, 32'h1);
    check(name, rd, exp);
  endtask

  task automatic reg_wr(input logic [1:0] off, input logic [31:0] wd);
    logic [31:0] rd;
    logic        got;
    bus_xfer(1'b1, BASE + {22'h0, off, 2'b00}, wd, 1'b0, 1'b0, 8'h00, rd, got);
    check("wr_ack", {31'h0, got}, 32'h1);
  endtask

  task automatic rx_push(input logic [7:0] b);
    @(negedge clk_i);
    rx_data  = b;
    rx_valid = 1'b1;
    @(negedge clk_i);
    rx_valid = 1'b0;
  endtask

  typedef struct {
    logic        we;
    logic [1:0]  off;
    logic [31:0] wd;
    logic [31:0] exp_rd;
    logic        exp_irq;
  } vec_t;

  vec_t vecs [13];

  initial begin
    logic [31:0] rd;
    logic        got;
    int          acks;

    //         we    off    wdata         exp_rd        irq
    vecs[0]  = '{1'b0, 2'd2, 32'h0,        32'h0000000A, 1'b0};
    vecs[1]  = '{1'b0, 2'd3, 32'h0,        32'h00000000, 1'b0};
    vecs[2]  = '{1'b1, 2'd3, 32'h00000006, 32'h0,        1'b1};
    vecs[3]  = '{1'b0, 2'd3, 32'h0,        32'h00000006, 1'b1};
    vecs[4]  = '{1'b1, 2'd0, 32'hFFFFFF3C, 32'h0,        1'b0};
    vecs[5]  = '{1'b0, 2'd0, 32'h0,        32'h00000000, 1'b0};
    vecs[6]  = '{1'b0, 2'd2, 32'h0,        32'h00000108, 1'b0};
    vecs[7]  = '{1'b0, 2'd1, 32'h0,        32'h00000000, 1'b0};
    vecs[8]  = '{1'b1, 2'd2, 32'h0000FFFF, 32'h0,        1'b0};
    vecs[9]  = '{1'b0, 2'd2, 32'h0,        32'h00000108, 1'b0};
    vecs[10] = '{1'b1, 2'd3, 32'h00000031, 32'h0,        1'b0};
    vecs[11] = '{1'b0, 2'd3, 32'h0,        32'h00000001, 1'b0};
    vecs[12] = '{1'b0, 2'd2, 32'h0,        32'h00000108, 1'b0};

    sif.adr_i  = '0;
    sif.dat_i  = '0;
    sif.we_i   = 1'b0;
    sif.stb_i  = 1'b0;
    sif.cyc_i  = 1'b0;
    sif.tagn_i = 1'b0;

    // ---- reset state ----
    #2 rst_i = 1'b1;
    repeat (2) @(posedge clk_i);
    #1;
    check("rst_ack",    {31'h0, sif.ack_o},  32'h0);
    check("rst_dat",    sif.dat_o,           32'h0);
    check("rst_tagn",   {31'h0, sif.tagn_o}, 32'h0);
    check("rst_txv",    {31'h0, tx_valid},   32'h0);
    check("rst_irq",    {31'h0, irq},        32'h0);
    @(negedge clk_i);
    rst_i = 1'b0;

    // ---- table-driven register accesses (tx_ready=0) ----
    for (int i = 0; i < 13; i++) begin
      bus_xfer(vecs[i].we, BASE + {22'h0, vecs[i].off, 2'b00}, vecs[i].wd, i[0],
               1'b0, 8'h00, rd, got);
      check($sformatf("vec%0d_ack", i), {31'h0, got}, 32'h1);
      if (!vecs[i].we) check($sformatf("vec%0d_rd", i), rd, vecs[i].exp_rd);
      check($sformatf("vec%0d_irq", i), {31'h0, irq}, {31'h0, vecs[i].exp_irq});
    end
    check("en_txv",  {31'h0, tx_valid}, 32'h1);
    check("en_txd",  {24'h0, tx_data},  32'h3C);

    // ---- TX byte flows straight out with EN=1, tx_ready=1 ----
    do_reset();
    reg_wr(2'd3, 32'h1);
    tx_ready = 1'b1;
    bus_xfer(1'b1, BASE, 32'h000000A5, 1'b1, 1'b0, 8'h00, rd, got);
    check("a5_ack",   {31'h0, got},      32'h1);
    check("a5_txv",   {31'h0, snap_txv}, 32'h1);
    check("a5_txd",   {24'h0, snap_txd}, 32'hA5);
    check("a5_drain", {31'h0, tx_valid}, 32'h0);
    reg_rd("a5_status", 2'd2, 32'h0000000A);
    tx_ready = 1'b0;

    // ---- RX bytes read back in order ----
    do_reset();
    rx_push(8'h11);
    rx_push(8'h22);
    reg_rd("rx_first",  2'd1, 32'h11);
    reg_rd("rx_second", 2'd1, 32'h22);
    reg_rd("rx_status", 2'd2, 32'h0000000A);

    // ---- TX overflow with EN=0 ----
    do_reset();
    for (int i = 0; i < 5; i++) reg_wr(2'd0, 32'h50 + i);
    reg_rd("txovf_status", 2'd2, 32'h00000429);
    check("txovf_irq", {31'h0, irq}, 32'h1);
    reg_wr(2'd3, 32'h20);
    reg_rd("txovf_clr_status", 2'd2, 32'h00000409);
    check("txovf_clr_irq", {31'h0, irq}, 32'h0);

    // ---- RX full: overrun, clear, then push paired with pop ----
    do_reset();
    for (int i = 1; i <= 4; i++) rx_push(8'(i));
    reg_rd("rxfull_status", 2'd2, 32'h00004006);
    rx_push(8'h55);
    reg_rd("rxovf_status", 2'd2, 32'h00004016);
    check("rxovf_irq", {31'h0, irq}, 32'h1);
    reg_wr(2'd3, 32'h10);
    reg_rd("rxovf_clr_status", 2'd2, 32'h00004006);
    bus_xfer(1'b0, BASE + 26'h4, 32'h0, 1'b0, 1'b1, 8'h66, rd, got);
    check("pushpop_ack", {31'h0, got}, 32'h1);
    check("pushpop_rd",  rd, 32'h01);
    reg_rd("pushpop_status", 2'd2, 32'h00004006);
    reg_rd("pushpop_rd2", 2'd1, 32'h02);
    reg_rd("pushpop_rd3", 2'd1, 32'h03);
    reg_rd("pushpop_rd4", 2'd1, 32'h04);
    reg_rd("pushpop_rd5", 2'd1, 32'h66);

    // ---- address miss, then long strobe on a hit ----
    do_reset();
    bus_xfer(1'b1, BASE + 26'h40, 32'h99, 1'b0, 1'b0, 8'h00, rd, got);
    check("miss_no_ack", {31'h0, got}, 32'h0);
    reg_rd("miss_status", 2'd2, 32'h0000000A);
    rx_push(8'h77);
    rx_push(8'h88);
    acks = 0;
    @(negedge clk_i);
    sif.adr_i = BASE + 26'h4;
    sif.we_i  = 1'b0;
    sif.stb_i = 1'b1;
    sif.cyc_i = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk_i);
      #1;
      if (sif.ack_o) begin
        acks++;
        rd = sif.dat_o;
      end
    end
    @(negedge clk_i);
    sif.stb_i = 1'b0;
    sif.cyc_i = 1'b0;
    repeat (2) @(posedge clk_i);
    check("hold_acks", acks, 1);
    check("hold_rd",   rd, 32'h77);
    reg_rd("hold_status", 2'd2, 32'h00001002);

    // ---- reset asserted during ACK ----
    @(negedge clk_i);
    sif.adr_i = BASE;
    sif.dat_i = 32'h12;
    sif.we_i  = 1'b1;
    sif.stb_i = 1'b1;
    sif.cyc_i = 1'b1;
    @(posedge clk_i);
    #1;
    check("midrst_ack_before", {31'h0, sif.ack_o}, 32'h1);
    #2 rst_i = 1'b1;
    #1;
    check("midrst_ack_async", {31'h0, sif.ack_o}, 32'h0);
    @(negedge clk_i);
    sif.stb_i = 1'b0;
    sif.cyc_i = 1'b0;
    @(negedge clk_i);
    rst_i = 1'b0;
    reg_rd("midrst_status", 2'd2, 32'h0000000A);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
